// File: rtl/nonrestoring_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master issues start with operands; the slave returns busy/done and the results.
interface nonrestoring_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider, one non-restoring add/sub-and-shift iteration per clock.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   CALC  | WIDTH shift/add-or-subtract iterations, counter running down
//   CORR  | remainder fix-up, sign correction, results loaded, done pulsed
module nonrestoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nonrestoring_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] p;
  logic [WIDTH-1:0] qm;
  logic [WIDTH-1:0] mag_d;
  logic             sign_a;
  logic             sign_q;
  logic             dbz_pend;
  logic             ovf_pend;

  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_d_in;
  logic [WIDTH+1:0] md_ext;
  logic [WIDTH+1:0] p_sh;
  logic [WIDTH+1:0] p_step;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_out;
  logic [WIDTH-1:0] quo_out;

  // Magnitudes are kept unsigned, so |MIN| = 2^(WIDTH-1) is exact.
  always_comb begin
    mag_a_in = bus.dividend;
    mag_d_in = bus.divisor;
    if (bus.dividend[WIDTH-1]) mag_a_in = {WIDTH{1'b0}} - bus.dividend;
    if (bus.divisor[WIDTH-1])  mag_d_in = {WIDTH{1'b0}} - bus.divisor;

    md_ext = {2'b00, mag_d};
    p_sh   = {p[WIDTH:0], qm[WIDTH-1]};
    p_step = p[WIDTH+1] ? (p_sh + md_ext) : (p_sh - md_ext);

    rem_mag = p[WIDTH+1] ? (p[WIDTH-1:0] + mag_d) : p[WIDTH-1:0];
    rem_out = sign_a ? ({WIDTH{1'b0}} - rem_mag) : rem_mag;
    quo_out = sign_q ? ({WIDTH{1'b0}} - qm) : qm;
    if (dbz_pend) quo_out = {WIDTH{1'b1}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      p             <= '0;
      qm            <= '0;
      mag_d         <= '0;
      sign_a        <= 1'b0;
      sign_q        <= 1'b0;
      dbz_pend      <= 1'b0;
      ovf_pend      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.dbz       <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_a   <= bus.dividend[WIDTH-1];
            sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            qm       <= mag_a_in;
            mag_d    <= mag_d_in;
            p        <= '0;
            cnt      <= CW'(WIDTH);
            dbz_pend <= (bus.divisor == '0);
            ovf_pend <= (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (bus.divisor == {WIDTH{1'b1}});
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          p   <= p_step;
          qm  <= {qm[WIDTH-2:0], ~p_step[WIDTH+1]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= CORR;
        end
        CORR: begin
          bus.quotient  <= quo_out;
          bus.remainder <= rem_out;
          bus.dbz       <= dbz_pend;
          bus.ovf       <= ovf_pend;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
